// File: rtl/osc_bank_pkg.sv
// Shared defaults and allocation types for the polyphonic square-wave oscillator bank.
package osc_bank_pkg;

  localparam int unsigned OSC_CNT_BW     = 16;
  localparam int unsigned OSC_NOTE_BW    = 7;
  localparam int unsigned OSC_NUM_VOICES = 4;

  typedef enum logic [1:0] {
    ALLOC_NONE,
    ALLOC_RETRIG,
    ALLOC_FREE,
    ALLOC_STEAL
  } alloc_e;

endpackage

// File: rtl/osc_voice.sv
// One oscillator voice: half-period counter, wave toggle and the note/active registers.
module osc_voice
  import osc_bank_pkg::*;
#(
  parameter int unsigned CNT_BW  = OSC_CNT_BW,
  parameter int unsigned NOTE_BW = OSC_NOTE_BW
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [NOTE_BW-1:0] note_i,
  input  logic [CNT_BW-1:0]  half_cnt_i,
  output logic               active_o,
  output logic [NOTE_BW-1:0] note_o,
  output logic               wave_o
);

  logic [CNT_BW-1:0] half_cnt;
  logic [CNT_BW-1:0] counter;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      active_o <= 1'b0;
      note_o   <= '0;
      half_cnt <= '0;
      counter  <= '0;
      wave_o   <= 1'b0;
    end else if (load_i) begin
      active_o <= 1'b1;
      note_o   <= note_i;
      half_cnt <= half_cnt_i;
      counter  <= '0;
      wave_o   <= 1'b0;
    end else if (clear_i || !active_o) begin
      active_o <= 1'b0;
      counter  <= '0;
      wave_o   <= 1'b0;
    end else if (counter == half_cnt) begin
      counter  <= '0;
      wave_o   <= ~wave_o;
    end else begin
      counter  <= counter + 1'b1;
    end
  end

endmodule

// File: rtl/osc_bank.sv
// Polyphonic oscillator bank: note-on allocation (retrigger / lowest free / round-robin steal)
// over NUM_VOICES osc_voice instances, plus a registered popcount of the wave outputs.
module osc_bank
  import osc_bank_pkg::*;
#(
  parameter int unsigned NUM_VOICES = OSC_NUM_VOICES,
  parameter int unsigned CNT_BW     = OSC_CNT_BW,
  parameter int unsigned NOTE_BW    = OSC_NOTE_BW
) (
  input  logic                                clk_i,
  input  logic                                nrst_i,
  input  logic                                noteOnStrb_i,
  input  logic                                noteOffStrb_i,
  input  logic [NOTE_BW-1:0]                  note_i,
  input  logic [CNT_BW-1:0]                   halfCntPeriod_i,
  output logic [NUM_VOICES-1:0]               active_o,
  output logic [NUM_VOICES-1:0]               wave_o,
  output logic [$clog2(NUM_VOICES+1)-1:0]     mix_o,
  output logic                                steal_o
);

  localparam int unsigned PTR_BW = $clog2(NUM_VOICES);
  localparam int unsigned MIX_BW = $clog2(NUM_VOICES + 1);

  logic [NOTE_BW-1:0]    voice_note [NUM_VOICES];
  logic [NUM_VOICES-1:0] match_v;
  logic [NUM_VOICES-1:0] load_v;
  logic [NUM_VOICES-1:0] clear_v;
  logic [PTR_BW-1:0]     free_idx;
  logic [PTR_BW-1:0]     steal_ptr;
  logic                  any_free;
  logic [MIX_BW-1:0]     mix_d;
  alloc_e                alloc;

  // Match vector and lowest-index free voice.
  always_comb begin
    match_v  = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      match_v[i] = active_o[i] && (voice_note[i] == note_i);
      if (!active_o[i] && !any_free) begin
        any_free = 1'b1;
        free_idx = PTR_BW'(i);
      end
    end
  end

  // Note-on wins over a simultaneous note-off.
  always_comb begin
    alloc   = ALLOC_NONE;
    load_v  = '0;
    clear_v = '0;
    if (noteOnStrb_i) begin
      if (|match_v)      alloc = ALLOC_RETRIG;
      else if (any_free) alloc = ALLOC_FREE;
      else               alloc = ALLOC_STEAL;
    end
    case (alloc)
      ALLOC_RETRIG: load_v = match_v;
      ALLOC_FREE:   load_v[free_idx] = 1'b1;
      ALLOC_STEAL:  load_v[steal_ptr] = 1'b1;
      default:      if (noteOffStrb_i) clear_v = match_v;
    endcase
  end

  always_comb begin
    mix_d = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      mix_d = mix_d + MIX_BW'(wave_o[i]);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      steal_ptr <= '0;
      steal_o   <= 1'b0;
      mix_o     <= '0;
    end else begin
      steal_o <= (alloc == ALLOC_STEAL);
      mix_o   <= mix_d;
      if (alloc == ALLOC_STEAL) begin
        steal_ptr <= (steal_ptr == PTR_BW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    osc_voice #(
      .CNT_BW  (CNT_BW),
      .NOTE_BW (NOTE_BW)
    ) u_voice (
      .clk_i      (clk_i),
      .nrst_i     (nrst_i),
      .load_i     (load_v[v]),
      .clear_i    (clear_v[v]),
      .note_i     (note_i),
      .half_cnt_i (halfCntPeriod_i),
      .active_o   (active_o[v]),
      .note_o     (voice_note[v]),
      .wave_o     (wave_o[v])
    );
  end

endmodule

// File: tb/tb_osc_bank.sv
// Directed self-checking bench for osc_bank (4 voices, 16-bit counters, 7-bit notes).
module tb_osc_bank;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        noteOnStrb_i = 1'b0;
  logic        noteOffStrb_i = 1'b0;
  logic [6:0]  note_i = '0;
  logic [15:0] halfCntPeriod_i = '0;
  logic [3:0]  active_o;
  logic [3:0]  wave_o;
  logic [2:0]  mix_o;
  logic        steal_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  osc_bank #(
    .NUM_VOICES (4),
    .CNT_BW     (16),
    .NOTE_BW    (7)
  ) dut (
    .clk_i           (clk_i),
    .nrst_i          (nrst_i),
    .noteOnStrb_i    (noteOnStrb_i),
    .noteOffStrb_i   (noteOffStrb_i),
    .note_i          (note_i),
    .halfCntPeriod_i (halfCntPeriod_i),
    .active_o        (active_o),
    .wave_o          (wave_o),
    .mix_o           (mix_o),
    .steal_o         (steal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic note_on(input logic [6:0] n, input logic [15:0] h);
    noteOnStrb_i = 1'b1;
    note_i = n;
    halfCntPeriod_i = h;
    step();
    noteOnStrb_i = 1'b0;
  endtask

  task automatic note_off(input logic [6:0] n);
    noteOffStrb_i = 1'b1;
    note_i = n;
    step();
    noteOffStrb_i = 1'b0;
  endtask

  task automatic note_on_off(input logic [6:0] n, input logic [15:0] h);
    noteOnStrb_i = 1'b1;
    noteOffStrb_i = 1'b1;
    note_i = n;
    halfCntPeriod_i = h;
    step();
    noteOnStrb_i = 1'b0;
    noteOffStrb_i = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_active", 32'(active_o), 32'h0);
    check("rst_wave", 32'(wave_o), 32'h0);
    check("rst_mix", 32'(mix_o), 32'h0);
    check("rst_steal", 32'(steal_o), 32'h0);
    nrst_i = 1'b1;
    step();

    // Basic tone: half=3 -> period 8
    note_on(7'd60, 16'd3);
    check("tone_active", 32'(active_o), 32'h1);
    check("tone_wave_load", 32'(wave_o), 32'h0);
    step(3);
    check("tone_wave_pre", 32'(wave_o), 32'h0);
    step();
    check("tone_wave_rise", 32'(wave_o), 32'h1);
    check("tone_mix_lag", 32'(mix_o), 32'h0);
    step();
    check("tone_mix_rise", 32'(mix_o), 32'h1);
    step(2);
    check("tone_wave_hold", 32'(wave_o), 32'h1);
    step();
    check("tone_wave_fall", 32'(wave_o), 32'h0);
    check("tone_mix_hold", 32'(mix_o), 32'h1);
    step();
    check("tone_mix_fall", 32'(mix_o), 32'h0);
    note_off(7'd60);
    check("tone_off_active", 32'(active_o), 32'h0);
    check("tone_off_wave", 32'(wave_o), 32'h0);

    // Allocation to lowest free voice
    note_on(7'd60, 16'd5);
    check("alloc_a", 32'(active_o), 32'h1);
    note_on(7'd62, 16'd6);
    check("alloc_b", 32'(active_o), 32'h3);
    note_on(7'd64, 16'd7);
    check("alloc_c", 32'(active_o), 32'h7);
    check("alloc_nosteal", 32'(steal_o), 32'h0);
    note_off(7'd62);
    check("alloc_off62", 32'(active_o), 32'h5);
    check("alloc_off62_wave1", 32'(wave_o[1]), 32'h0);
    note_on(7'd65, 16'd2);
    check("alloc_reuse", 32'(active_o), 32'h7);
    note_off(7'd65);
    check("alloc_65_in_v1", 32'(active_o), 32'h5);
    note_off(7'd60);
    note_off(7'd64);
    check("alloc_clean", 32'(active_o), 32'h0);

    // Retrigger restarts the counter with the new half period
    note_on(7'd60, 16'd3);
    step(2);
    note_on(7'd60, 16'd9);
    check("retrig_active", 32'(active_o), 32'h1);
    check("retrig_steal", 32'(steal_o), 32'h0);
    check("retrig_wave0", 32'(wave_o), 32'h0);
    step(9);
    check("retrig_wave_pre", 32'(wave_o), 32'h0);
    step();
    check("retrig_wave_rise", 32'(wave_o), 32'h1);
    note_off(7'd60);
    check("retrig_off", 32'(active_o), 32'h0);

    // Round-robin stealing
    note_on(7'd60, 16'd1);
    note_on(7'd61, 16'd1);
    note_on(7'd62, 16'd1);
    note_on(7'd63, 16'd1);
    check("steal_full", 32'(active_o), 32'hF);
    check("steal_none_yet", 32'(steal_o), 32'h0);
    note_on(7'd70, 16'd4);
    check("steal_pulse", 32'(steal_o), 32'h1);
    step();
    check("steal_pulse_end", 32'(steal_o), 32'h0);
    note_on(7'd71, 16'd4);
    note_on(7'd72, 16'd4);
    note_on(7'd73, 16'd4);
    note_on(7'd74, 16'd4);
    check("steal_wrap_pulse", 32'(steal_o), 32'h1);
    note_off(7'd70);
    check("steal_70_gone", 32'(active_o), 32'hF);
    note_off(7'd74);
    check("steal_74_in_v0", 32'(active_o), 32'hE);
    note_off(7'd71);
    check("steal_71_in_v1", 32'(active_o), 32'hC);
    note_off(7'd72);
    note_off(7'd73);
    check("steal_clean", 32'(active_o), 32'h0);

    // Edge cases
    note_on_off(7'd60, 16'd3);
    check("edge_onoff_free", 32'(active_o), 32'h1);
    note_on_off(7'd60, 16'd3);
    check("edge_onoff_retrig", 32'(active_o), 32'h1);
    note_off(7'd99);
    check("edge_off_nomatch", 32'(active_o), 32'h1);
    note_off(7'd60);
    check("edge_off60", 32'(active_o), 32'h0);
    note_on(7'd50, 16'd0);
    check("edge_h0_load", 32'(wave_o), 32'h0);
    step();
    check("edge_h0_t1", 32'(wave_o), 32'h1);
    step();
    check("edge_h0_t2", 32'(wave_o), 32'h0);
    check("edge_h0_mix", 32'(mix_o), 32'h1);
    step();
    check("edge_h0_t3", 32'(wave_o), 32'h1);
    note_off(7'd50);
    check("edge_h0_off", 32'(active_o), 32'h0);

    // Asynchronous reset mid-operation; steal pointer (currently 1) must return to 0
    note_on(7'd60, 16'd2);
    note_on(7'd61, 16'd2);
    note_on(7'd62, 16'd2);
    step(3);
    check("mid_active", 32'(active_o), 32'h7);
    #3;
    nrst_i = 1'b0;
    #1;
    check("mid_rst_active", 32'(active_o), 32'h0);
    check("mid_rst_wave", 32'(wave_o), 32'h0);
    check("mid_rst_mix", 32'(mix_o), 32'h0);
    check("mid_rst_steal", 32'(steal_o), 32'h0);
    #2;
    nrst_i = 1'b1;
    step(2);
    check("post_rst_idle", 32'(active_o), 32'h0);
    note_on(7'd60, 16'd2);
    note_on(7'd61, 16'd2);
    note_on(7'd62, 16'd2);
    note_on(7'd63, 16'd2);
    note_on(7'd80, 16'd2);
    check("post_rst_steal", 32'(steal_o), 32'h1);
    note_off(7'd80);
    check("post_rst_ptr0", 32'(active_o), 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osc_bank.md
Name: osc_bank

Overview:
Polyphonic square-wave oscillator bank; next-generation replacement for the single-channel oscillator. Holds NUM_VOICES independent voices and allocates note-on events internally: retrigger on the same note, else lowest free voice, else round-robin voice stealing. Sits between the MIDI decoder (note strobes, half-period lookup) and the audio mixer/PWM output stage.

Parameters:
NUM_VOICES, 4, number of voices (>=2)
CNT_BW, 16, half-period counter width (default equals global OSC_CNT_BW)
NOTE_BW, 7, MIDI note number width

Ports:
clk_i  input  1  system clock
nrst_i  input  1  asynchronous active-low reset
noteOnStrb_i  input  1  one-cycle note-on strobe
noteOffStrb_i  input  1  one-cycle note-off strobe
note_i  input  NOTE_BW  note number qualifying either strobe
halfCntPeriod_i  input  CNT_BW  half period in clocks minus 1; sampled on note-on only
active_o  output  NUM_VOICES  per-voice enabled flags
wave_o  output  NUM_VOICES  per-voice square outputs
mix_o  output  $clog2(NUM_VOICES+1)  registered count of voices whose wave is high
steal_o  output  1  one-cycle pulse: last note-on stole a voice

Behaviour:
- Clock/reset: single clock clk_i; reset nrst_i is asynchronous, active-low. Reset clears all voice state, the steal pointer, mix_o and steal_o to 0.
- Per-voice state: active, note, halfCnt, counter, wave.
- Active voice:
  - counter increments each cycle.
  - When counter == halfCnt: counter -> 0 and wave toggles on the same edge.
  - Period is 2*(halfCnt+1) clocks; halfCnt = 0 toggles every cycle.
- Inactive voice: counter held at 0; wave forced to 0 on the deactivation edge.
- Note-on allocation, priority order, decided in the strobe cycle, effective the next edge:
  1. An active voice with note == note_i is retriggered.
  2. Otherwise, the lowest-index inactive voice is used.
  3. Otherwise, the voice at stealPtr is stolen; stealPtr increments with wrap (NUM_VOICES-1 -> 0); steal_o = 1 for one cycle.
- On allocation the voice loads active = 1, note = note_i, halfCnt = halfCntPeriod_i, counter = 0, wave = 0.
- stealPtr changes only on a steal.
- Note-off: clears active for the voice whose note matches (at most one, guaranteed by the retrigger rule). No match: ignored, no state change.
- Simultaneous noteOnStrb_i and noteOffStrb_i: note-on is processed, note-off is ignored.
- mix_o: popcount of wave vector, registered; lags wave_o by 1 cycle.
- Latency:
  - active_o rises 1 cycle after the note-on strobe.
  - First wave toggle occurs halfCnt+1 cycles after active_o rises.
  - active_o and wave_o fall 1 cycle after a note-off strobe.
- Strobes asserted for several consecutive cycles are each processed; the retrigger rule makes a repeated note-on restart the same voice.
- Reset asserted mid-tone: all outputs go to 0 immediately (asynchronous); after release, no voice is active until the next note-on.

Decomposition:
- Shared defines in global.v: OSC_CNT_BW, OSC_NOTE_BW, OSC_NUM_VOICES defaults.
- Sub-module osc_voice: one voice (counter, compare, wave toggle, load/clear controls, active/note registers). Generated NUM_VOICES times.
- osc_bank keeps allocation logic (match vector, priority encoder, steal pointer) and the mix popcount.

Test Plan:
- Basic tone: reset, note-on note=60 half=3 -> active_o=0001 next cycle; wave_o[0] toggles every 4 cycles (period 8); mix_o follows 1 cycle later.
- Allocation: note-ons 60/62/64 with half=5/6/7 on separate cycles -> voices 0, 1, 2 active; note-off 62 -> active_o=0101, wave_o[1]=0; new note-on 65 -> lands in voice 1.
- Retrigger: note-on 60 half=3, wait 2 cycles, note-on 60 half=9 -> still only voice 0 active; counter restarts; next toggle after 10 cycles; steal_o stays 0.
- Stealing: fill 4 voices (notes 60-63), note-on 70 -> voice 0 takes note 70, steal_o pulses; note-on 71 -> voice 1; after 4 steals the pointer wraps to voice 0.
- Edge cases: note-on 60 and note-off 60 in the same cycle -> voice active; note-off 99 with no match -> no change; half=0 -> wave toggles every cycle.
- Reset mid-operation: 3 voices sounding, pulse nrst_i low asynchronously between edges -> all outputs 0 immediately; after release, next steal targets voice 0.
